btn_das: RTL and testbench
==========================

Name: btn_das

Overview:
- Per-button conditioner between the raw `usr_btn` pins and the game `control` block.
- Synchronises and debounces each button, then emits single-cycle action pulses with Tetris-style delayed auto shift (DAS) and auto-repeat (ARR).
- `control` consumes the pulses to generate `state_type` move/rotate/drop commands.
- Runs in the 50 MHz pixel/game clock domain.

Parameters:
- N_BTN, 4, number of independent buttons.
- DEBOUNCE_CYC, 500000, consecutive stable cycles (10 ms at 50 MHz) required to accept a level change.
- DAS_CYC, 8500000, cycles from initial press pulse to first repeat pulse (170 ms).
- ARR_CYC, 2500000, cycles between successive repeat pulses (50 ms).
- CNT_W, 24, width of debounce and DAS/ARR counters; must hold max(DEBOUNCE_CYC, DAS_CYC, ARR_CYC).

Ports:
- clk  input  1  50 MHz clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_in  input  N_BTN  raw, asynchronous, bouncy button levels (1 = pressed).
- en  input  1  pulse enable from `control`; 0 while the game is not ready.
- press  output  N_BTN  one-cycle action pulse per button (initial press and repeats).
- held  output  N_BTN  debounced button level.
- any_press  output  1  OR of `press`, registered in the same cycle as `press`.

Behaviour:
- **Reset values:** while reset is high, all flops clear asynchronously. `press=0`, `held=0`, `any_press=0`, every FSM is in IDLE, all counters are 0. The debounced state resets to released.
- **Synchroniser:** a 2-flop synchroniser per bit produces `sync[i]`.
- **Debounce:**
  - A per-button counter increments while `sync[i] != held[i]` and clears to 0 on any cycle where they are equal.
  - When the counter reaches DEBOUNCE_CYC-1 and the mismatch persists, `held[i]` toggles on that edge and the counter clears.
  - Bounces shorter than DEBOUNCE_CYC cycles never change `held`.
- **Latency:** if `btn_in[i]` is sampled high at edge t and stays high, `held[i]` rises at edge t+DEBOUNCE_CYC+1 and `press[i]` rises at edge t+DEBOUNCE_CYC+2 (registered output).
- **Per-button FSM** with states IDLE, DELAY, REPEAT, LOCKED and one shared-width counter `rc` per button:
  - **IDLE:**
    - `held` rises and `en=1`: pulse `press`, set `rc=0`, go to DELAY.
    - `held` rises and `en=0`: go to LOCKED, no pulse.
  - **DELAY:**
    - `rc` increments each cycle.
    - At `rc==DAS_CYC-1`: pulse `press`, set `rc=0`, go to REPEAT.
  - **REPEAT:**
    - `rc` increments each cycle.
    - At `rc==ARR_CYC-1`: pulse `press`, set `rc=0`.
    - With ARR_CYC=1, `press` is high every cycle.
  - **LOCKED:** no pulses; go to IDLE when `held` falls.
  - **From any state:** `held` falling goes to IDLE on the same edge, with no pulse on that edge.
  - **From DELAY/REPEAT:** `en=0` goes to LOCKED with no pulse. A button held across `en` rising therefore does not fire until it is released and pressed again.
- **Precedence:** release beats every other transition. `en=0` beats repeat or DAS expiry in the same cycle.
- **Independence:** buttons are fully independent. Simultaneous presses produce simultaneous pulses, and `any_press` is 1 if any bit of `press` is 1.
- **Counter width:** counters never wrap, because they clear at terminal count. Elaboration fails (`$error`) if any *_CYC is 0 or does not fit in CNT_W.
- **Reset mid-operation:** an in-flight pulse is cleared immediately. After reset release a still-held button must re-debounce from released, then behaves as a fresh press.

Optional Feature:
- Macro: BTN_DAS_REPEAT_EN.
- **Defined:** DELAY/REPEAT behave as specified above.
- **Undefined:** DELAY and REPEAT are not built; IDLE with `held` rising and `en=1` pulses `press` once and goes to LOCKED, giving one pulse per physical press. `held` and `en` handling are unchanged, and the `rc` counters are removed.

Test Plan:
All scenarios use DEBOUNCE_CYC=4, DAS_CYC=10, ARR_CYC=3, CNT_W=8, BTN_DAS_REPEAT_EN defined unless stated.
1. **Clean press:** `btn_in[0]` high from edge 0 for 40 cycles, `en=1` -> `held[0]` rises at edge 5. `press[0]` pulses at edges 6, 16, 19, 22, 25, … and `any_press` mirrors it. `press` goes to 0 the edge after `held` falls.
2. **Bounce:** `btn_in[1]` toggles 1,0,1,0 for single cycles, then high for 3 cycles, then low -> `held[1]` and `press[1]` stay 0 throughout.
3. **Enable gating:** press `btn_in[2]` with `en=0`, raise `en` at cycle 20 while still held -> no pulse. Release, wait 10 cycles, press again -> pulse 6 cycles after the new press.
4. **Mid-repeat disable:** hold `btn_in[3]` until REPEAT, drop `en` on the cycle a repeat is due -> no pulse that cycle and no further pulses while held.
5. **Simultaneous and reset:**
   - All 4 buttons pressed on the same edge -> `press` equals 4'b1111 on the same edges.
   - Assert reset at cycle 17 for 2 cycles with buttons held -> outputs 0 immediately. First post-reset pulse is 6 cycles after reset deassertion.
6. **Macro undefined:** scenario 1 stimulus -> exactly one `press[0]` pulse, at edge 6.

Source files
------------

// File: rtl/btn_das.sv
// Per-button synchroniser, debouncer and action-pulse generator with DAS/ARR auto-repeat.
// Define BTN_DAS_REPEAT_EN to build auto-repeat; otherwise each physical press fires once.
module btn_das #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned DAS_CYC      = 8500000,
    parameter int unsigned ARR_CYC      = 2500000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             en,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] held,
    output logic             any_press
);
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    if (DEBOUNCE_CYC == 0 || 64'(DEBOUNCE_CYC) > CNT_MAX) begin : g_bad_debounce
        $error("btn_das: DEBOUNCE_CYC must be nonzero and fit in CNT_W bits");
    end
    if (DAS_CYC == 0 || 64'(DAS_CYC) > CNT_MAX) begin : g_bad_das
        $error("btn_das: DAS_CYC must be nonzero and fit in CNT_W bits");
    end
    if (ARR_CYC == 0 || 64'(ARR_CYC) > CNT_MAX) begin : g_bad_arr
        $error("btn_das: ARR_CYC must be nonzero and fit in CNT_W bits");
    end

`ifdef BTN_DAS_REPEAT_EN
    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYC - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYC - 1);
    typedef enum logic [1:0] {StIdle, StDelay, StRepeat, StLocked} state_e;
`else
    typedef enum logic [0:0] {StIdle, StLocked} state_e;
`endif

    logic [N_BTN-1:0] fire;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [1:0]       sync_q;
        logic [CNT_W-1:0] db_cnt;
        logic             held_q;
        logic             press_q;
        logic             fire_b;
        state_e           state;
`ifdef BTN_DAS_REPEAT_EN
        logic [CNT_W-1:0] rc;
`endif

        // Debounce: held toggles only after DEBOUNCE_CYC consecutive mismatching cycles.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= 2'b00;
                db_cnt <= '0;
                held_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[0], btn_in[i]};
                if (sync_q[1] == held_q) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    db_cnt <= '0;
                    held_q <= ~held_q;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        // Release and en=0 suppress any pulse, so both gate every firing condition.
        always_comb begin
            fire_b = 1'b0;
            if (held_q && en) begin
                unique case (state)
                    StIdle:   fire_b = 1'b1;
`ifdef BTN_DAS_REPEAT_EN
                    StDelay:  fire_b = (rc == DAS_LAST);
                    StRepeat: fire_b = (rc == ARR_LAST);
`endif
                    default:  fire_b = 1'b0;
                endcase
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state   <= StIdle;
                press_q <= 1'b0;
`ifdef BTN_DAS_REPEAT_EN
                rc      <= '0;
`endif
            end else begin
                press_q <= fire_b;
                if (!held_q) begin
                    state <= StIdle;
                end else begin
                    unique case (state)
                        StIdle: begin
`ifdef BTN_DAS_REPEAT_EN
                            state <= en ? StDelay : StLocked;
                            rc    <= '0;
`else
                            state <= StLocked;
`endif
                        end
`ifdef BTN_DAS_REPEAT_EN
                        StDelay: begin
                            if (!en) begin
                                state <= StLocked;
                            end else if (rc == DAS_LAST) begin
                                state <= StRepeat;
                                rc    <= '0;
                            end else begin
                                rc <= rc + 1'b1;
                            end
                        end
                        StRepeat: begin
                            if (!en) begin
                                state <= StLocked;
                            end else if (rc == ARR_LAST) begin
                                rc <= '0;
                            end else begin
                                rc <= rc + 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end

        assign held[i]  = held_q;
        assign press[i] = press_q;
        assign fire[i]  = fire_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |fire;
        end
    end
endmodule

// File: tb/tb_btn_das.sv
// Directed bench for btn_das with DEBOUNCE_CYC=4, DAS_CYC=10, ARR_CYC=3, CNT_W=8.
// Expectations follow BTN_DAS_REPEAT_EN: repeat pulses only when it is defined.
module tb_btn_das;
`ifdef BTN_DAS_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] btn_in;
    logic [3:0] press;
    logic [3:0] held;
    logic       any_press;

    int n_checks = 0;
    int n_errors = 0;

    btn_das #(
        .N_BTN       (4),
        .DEBOUNCE_CYC(4),
        .DAS_CYC     (10),
        .ARR_CYC     (3),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .en       (en),
        .press    (press),
        .held     (held),
        .any_press(any_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        btn_in = 4'h0;
        en     = 1'b1;
        step;
        step;
        reset = 1'b0;
    endtask

    function automatic logic [8:0] outs();
        return {held, press, any_press};
    endfunction

    function automatic logic [8:0] exp_outs(input logic [3:0] h, input logic [3:0] p);
        return {h, p, |p};
    endfunction

    initial begin
        bit ep;
        bit eh;

        // Reset state
        reset  = 1'b1;
        btn_in = 4'hF;
        en     = 1'b1;
        step;
        check("reset_state", 32'(outs()), 32'(exp_outs(4'h0, 4'h0)));

        // 1: clean press on button 0; released at edge 40, held falls at 45
        do_reset;
        btn_in = 4'b0001;
        for (int k = 0; k < 56; k++) begin
            if (k == 40) btn_in = 4'b0000;
            step;
            eh = (k >= 5 && k <= 44);
            ep = (k == 6) || (REP && k >= 16 && k <= 45 && (k - 16) % 3 == 0);
            check($sformatf("clean e%0d", k), 32'(outs()),
                  32'(exp_outs({3'b000, eh}, {3'b000, ep})));
        end

        // 2: bounce on button 1; longest stable run is DEBOUNCE_CYC-1
        do_reset;
        for (int k = 0; k < 16; k++) begin
            btn_in = (k == 0 || k == 2 || (k >= 4 && k <= 6)) ? 4'b0010 : 4'b0000;
            step;
            check($sformatf("bounce e%0d", k), 32'(outs()), 32'(exp_outs(4'h0, 4'h0)));
        end

        // 3: enable gating on button 2; second press at edge 46 fires at 52
        do_reset;
        en = 1'b0;
        for (int k = 0; k < 61; k++) begin
            en     = (k >= 20);
            btn_in = (k < 30 || k >= 46) ? 4'b0100 : 4'b0000;
            step;
            eh = (k >= 5 && k <= 34) || (k >= 51);
            ep = (k == 52);
            check($sformatf("gate e%0d", k), 32'(outs()),
                  32'(exp_outs({1'b0, eh, 2'b00}, {1'b0, ep, 2'b00})));
        end

        // 4: en drops exactly when the repeat at edge 22 is due
        do_reset;
        btn_in = 4'b1000;
        for (int k = 0; k < 41; k++) begin
            en = (k != 22);
            step;
            eh = (k >= 5);
            ep = (k == 6) || (REP && (k == 16 || k == 19));
            check($sformatf("mid_dis e%0d", k), 32'(outs()),
                  32'(exp_outs({eh, 3'b000}, {ep, 3'b000})));
        end

        // 5: all buttons together, then reset over edges 17-18 while held
        do_reset;
        btn_in = 4'hF;
        for (int k = 0; k < 17; k++) begin
            step;
            eh = (k >= 5);
            ep = (k == 6) || (REP && k == 16);
            check($sformatf("simul e%0d", k), 32'(outs()),
                  32'(exp_outs({4{eh}}, {4{ep}})));
        end
        reset = 1'b1;
        #1;
        check("reset_async", 32'(outs()), 32'(exp_outs(4'h0, 4'h0)));
        step;
        check("reset_e17", 32'(outs()), 32'(exp_outs(4'h0, 4'h0)));
        step;
        check("reset_e18", 32'(outs()), 32'(exp_outs(4'h0, 4'h0)));
        reset = 1'b0;
        for (int k = 19; k < 33; k++) begin
            step;
            eh = (k >= 24);
            ep = (k == 25);
            check($sformatf("post_rst e%0d", k), 32'(outs()),
                  32'(exp_outs({4{eh}}, {4{ep}})));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
